// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared IF/ID pipeline definitions: data width, the NOP encoding presented
// to decode when nothing is available, the fetch FSM state type and the
// instruction buffer entry layout.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } ifid_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of ifid_entry_t. Head is read combinationally from the
// storage registers. Flush empties the FIFO and wins over push/pop.
// The caller never pushes when full nor pops when empty.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   push, push_data  write one entry at the tail
//   pop              retire the head entry
//   flush            discard every entry (count = 0 next cycle)
//   head             entry at the head (undefined while count = 0)
//   count            number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  ifid_entry_t   push_data,
    input  logic          pop,
    input  logic          flush,
    output ifid_entry_t   head,
    output logic [CW-1:0] count
);

    ifid_entry_t   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // NOTE: the storage array is deliberately left without reset; count gates
    // every use of its contents, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Holds the PC, issues in-order 32-bit fetches,
// buffers returned words with their PCs and presents them to decode.
// A credit rule (buffered + in-flight < DEPTH) guarantees that every response
// has a buffer slot, so memory responses need no backpressure. A redirect
// flushes the buffer and marks every outstanding request as stale.
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        fetch request handshake and address
//   imem_resp_valid/data             in-order response, no backpressure
//   IFID_instreg, IFID_npc           head instruction and its own PC
//   IFID_ready                       head entry valid
//   IDIF_stall                       decode holds the head this cycle
//   EXIF_branch, EXIF_target         redirect pulse and target PC
//   fetch_misaligned                 sticky: a redirect target was misaligned
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic [31:0]     IFID_instreg,
    output logic [XLEN-1:0] IFID_npc,
    output logic            IFID_ready,
    input  logic            IDIF_stall,
    input  logic            EXIF_branch,
    input  logic [XLEN-1:0] EXIF_target,
    output logic            fetch_misaligned
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;      // PC of the oldest non-dropped outstanding request
    logic [XLEN-1:0] target_aligned;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_cnt_next;
    logic [CW:0]     occupancy;
    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    logic            any_req;      // a request was accepted since reset
    ifid_entry_t     head;
    ifid_entry_t     push_entry;

    assign occupancy      = {1'b0, count} + {1'b0, inflight};
    assign target_aligned = {EXIF_target[XLEN-1:2], 2'b00};
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A zero-latency memory answers in the accepting cycle, so a response is
    // legitimate when something is outstanding or is being accepted now.
    // Anything else is a leftover from before a reset and is ignored.
    assign resp_fire = imem_resp_valid && ((inflight != '0) || req_fire);

    // Redirect kills the same-cycle response along with all older requests.
    assign push = resp_fire && (drop_cnt == '0) && !EXIF_branch;
    assign pop  = IFID_ready && !IDIF_stall && !EXIF_branch;

    assign inflight_next = inflight + CW'(req_fire) - CW'(resp_fire);

    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN:  imem_req_valid = (occupancy < DEPTH_W);
        endcase
    end

    always_comb begin
        drop_cnt_next = drop_cnt;
        if (EXIF_branch)                      drop_cnt_next = inflight_next;
        else if (resp_fire && drop_cnt != '0) drop_cnt_next = drop_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= BOOT;
            pc               <= RESET_PC;
            resp_pc          <= RESET_PC;
            inflight         <= '0;
            drop_cnt         <= '0;
            fetch_misaligned <= 1'b0;
            any_req          <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= inflight_next;
            drop_cnt <= drop_cnt_next;
            if (req_fire) any_req <= 1'b1;
            if (EXIF_branch) begin
                pc      <= target_aligned;
                resp_pc <= target_aligned;
                if (EXIF_target[1:0] != 2'b00) fetch_misaligned <= 1'b1;
            end else begin
                if (req_fire) pc      <= pc + 64'd4;
                if (push)     resp_pc <= resp_pc + 64'd4;
            end
        end
    end

    assign push_entry = '{instr: imem_resp_data, pc: resp_pc};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (EXIF_branch),
        .head      (head),
        .count     (count)
    );

    assign IFID_ready   = (count != '0);
    assign IFID_instreg = IFID_ready ? head.instr : NOP_INSTR;
    assign IFID_npc     = IFID_ready ? head.pc    : '0;

    a_credit: assert property (@(posedge clk) disable iff (!reset)
        occupancy <= DEPTH_W);
    a_drop: assert property (@(posedge clk) disable iff (!reset)
        drop_cnt <= inflight);
    a_align: assert property (@(posedge clk) disable iff (!reset)
        imem_req_addr[1:0] == 2'b00);
    a_resp: assert property (@(posedge clk) disable iff (!reset)
        !(imem_resp_valid && inflight == '0 && !req_fire && any_req));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (RESET_PC = 0x1000, DEPTH = 2). The memory
// model returns the request address as the instruction word after a
// programmable latency (0 = answered in the accepting cycle).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] IFID_instreg;
    logic [63:0] IFID_npc;
    logic        IFID_ready;
    logic        IDIF_stall;
    logic        EXIF_branch;
    logic [63:0] EXIF_target;
    logic        fetch_misaligned;

    int checks = 0;
    int errors = 0;

    // memory model controls
    logic        mem_ready = 1'b1;
    logic        mem_flush = 1'b1;
    int unsigned mem_lat   = 0;
    int unsigned mcyc      = 0;
    logic        sv [8];
    logic [31:0] sa [8];

    always #5 clk = ~clk;

    assign imem_req_ready = mem_ready;

    fetch_unit #(.RESET_PC(64'h1000), .DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .IFID_instreg     (IFID_instreg),
        .IFID_npc         (IFID_npc),
        .IFID_ready       (IFID_ready),
        .IDIF_stall       (IDIF_stall),
        .EXIF_branch      (EXIF_branch),
        .EXIF_target      (EXIF_target),
        .fetch_misaligned (fetch_misaligned)
    );

    // Mid-cycle: record this cycle's accept, then present whatever is due.
    always @(negedge clk) begin
        if (mem_flush) begin
            for (int i = 0; i < 8; i++) sv[i] = 1'b0;
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end else begin
            if (imem_req_valid && mem_ready) begin
                sv[(mcyc + mem_lat) % 8] = 1'b1;
                sa[(mcyc + mem_lat) % 8] = imem_req_addr[31:0];
            end
            imem_resp_valid = sv[mcyc % 8];
            imem_resp_data  = sa[mcyc % 8];
            sv[mcyc % 8]    = 1'b0;
        end
        mcyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Returns just after the releasing edge: the caller is in the BOOT cycle.
    task automatic reset_dut(input int unsigned lat);
        reset       = 1'b0;
        IDIF_stall  = 1'b0;
        EXIF_branch = 1'b0;
        EXIF_target = 64'h0;
        mem_ready   = 1'b1;
        mem_flush   = 1'b1;
        mem_lat     = lat;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_flush = 1'b0;
    endtask

    // Expects n consecutive deliveries from 'first' upward, data == address.
    task automatic watch(input string name, input logic [63:0] first, input int n, input int bound);
        logic [63:0] exp;
        int          got;
        exp = first;
        got = 0;
        for (int c = 0; c < bound && got < n; c++) begin
            samp();
            if (IFID_ready) begin
                check({name, "_npc"}, IFID_npc, exp);
                check({name, "_instr"}, {32'h0, IFID_instreg}, {32'h0, exp[31:0]});
                exp = exp + 64'd4;
                got++;
            end
        end
        check({name, "_delivered"}, 64'(got), 64'(n));
    endtask

    typedef struct {
        logic        stall;
        logic        rdy;
        logic [63:0] npc;
        logic [31:0] instr;
        logic        rv;
        logic [63:0] addr;
    } vec_t;

    vec_t vecs [14];

    initial begin
        reset           = 1'b0;
        IDIF_stall      = 1'b0;
        EXIF_branch     = 1'b0;
        EXIF_target     = 64'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Streaming at zero latency, then a 5-cycle stall (cycles 5..9).
        //            stall  rdy    npc          instr         rv     addr
        vecs[0]  = '{1'b0, 1'b0, 64'h0,    32'h0000_0013, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 1'b0, 64'h0,    32'h0000_0013, 1'b1, 64'h1000};
        vecs[2]  = '{1'b0, 1'b1, 64'h1000, 32'h0000_1000, 1'b1, 64'h1004};
        vecs[3]  = '{1'b0, 1'b1, 64'h1004, 32'h0000_1004, 1'b1, 64'h1008};
        vecs[4]  = '{1'b0, 1'b1, 64'h1008, 32'h0000_1008, 1'b1, 64'h100C};
        vecs[5]  = '{1'b1, 1'b1, 64'h100C, 32'h0000_100C, 1'b1, 64'h1010};
        vecs[6]  = '{1'b1, 1'b1, 64'h100C, 32'h0000_100C, 1'b0, 64'h0};
        vecs[7]  = '{1'b1, 1'b1, 64'h100C, 32'h0000_100C, 1'b0, 64'h0};
        vecs[8]  = '{1'b1, 1'b1, 64'h100C, 32'h0000_100C, 1'b0, 64'h0};
        vecs[9]  = '{1'b1, 1'b1, 64'h100C, 32'h0000_100C, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 1'b1, 64'h100C, 32'h0000_100C, 1'b0, 64'h0};
        vecs[11] = '{1'b0, 1'b1, 64'h1010, 32'h0000_1010, 1'b1, 64'h1014};
        vecs[12] = '{1'b0, 1'b1, 64'h1014, 32'h0000_1014, 1'b1, 64'h1018};
        vecs[13] = '{1'b0, 1'b1, 64'h1018, 32'h0000_1018, 1'b1, 64'h101C};

        // Reset values while reset is held.
        #2;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_ready", IFID_ready, 1'b0);
        check("rst_instr", IFID_instreg, 32'h0000_0013);
        check("rst_npc", IFID_npc, 64'h0);
        check("rst_misaligned", fetch_misaligned, 1'b0);

        // Streaming and stall table.
        reset_dut(0);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) cyc();
            IDIF_stall = vecs[i].stall;
            samp();
            check($sformatf("vec%0d_ready", i), IFID_ready, vecs[i].rdy);
            check($sformatf("vec%0d_npc", i), IFID_npc, vecs[i].npc);
            check($sformatf("vec%0d_instr", i), IFID_instreg, vecs[i].instr);
            check($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].rv);
            if (vecs[i].rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].addr);
        end

        // Latency 3: redirect with 0x1008 and 0x100C both outstanding.
        reset_dut(3);
        repeat (7) cyc();
        samp();
        check("t3_pre_req_valid", imem_req_valid, 1'b1);
        check("t3_pre_req_addr", imem_req_addr, 64'h100C);
        cyc();
        EXIF_branch = 1'b1;
        EXIF_target = 64'h2000;
        samp();
        check("t3_br_req_valid", imem_req_valid, 1'b0);
        cyc();
        EXIF_branch = 1'b0;
        samp();
        check("t3_flush_ready", IFID_ready, 1'b0);
        check("t3_credit_hold", imem_req_valid, 1'b0);
        cyc();
        samp();
        check("t3_new_req_valid", imem_req_valid, 1'b1);
        check("t3_new_req_addr", imem_req_addr, 64'h2000);
        cyc();
        samp();
        check("t3_next_req_addr", imem_req_addr, 64'h2004);
        watch("t3", 64'h2000, 3, 20);

        // Latency 1: redirect coincides with an accept (0x1004) and a
        // response (0x1000); drop count must come out as 1.
        reset_dut(1);
        cyc();
        cyc();
        EXIF_branch = 1'b1;
        EXIF_target = 64'h2000;
        samp();
        check("t4_br_req_addr", imem_req_addr, 64'h1004);
        check("t4_br_req_valid", imem_req_valid, 1'b1);
        cyc();
        EXIF_branch = 1'b0;
        samp();
        check("t4_ready_after", IFID_ready, 1'b0);
        check("t4_req_addr", imem_req_addr, 64'h2000);
        cyc();
        samp();
        check("t4_ready_drop", IFID_ready, 1'b0);
        check("t4_req_addr2", imem_req_addr, 64'h2004);
        watch("t4", 64'h2000, 4, 20);

        // Misaligned target while the FIFO is full and stalled.
        reset_dut(0);
        IDIF_stall = 1'b1;
        repeat (3) cyc();
        EXIF_branch = 1'b1;
        EXIF_target = 64'h3002;
        samp();
        check("t5_full_npc", IFID_npc, 64'h1000);
        check("t5_pre_misaligned", fetch_misaligned, 1'b0);
        cyc();
        EXIF_branch = 1'b0;
        EXIF_target = 64'h0;
        IDIF_stall  = 1'b0;
        samp();
        check("t5_flush_ready", IFID_ready, 1'b0);
        check("t5_misaligned", fetch_misaligned, 1'b1);
        check("t5_req_addr", imem_req_addr, 64'h3000);
        watch("t5", 64'h3000, 3, 20);
        cyc();
        EXIF_branch = 1'b1;
        EXIF_target = 64'h4000;
        cyc();
        EXIF_branch = 1'b0;
        samp();
        check("t5_sticky", fetch_misaligned, 1'b1);
        cyc();
        reset = 1'b0;
        #1;
        check("t5_rst_misaligned", fetch_misaligned, 1'b0);
        cyc();
        reset = 1'b1;

        // Mid-stream reset with two requests outstanding at latency 3; the
        // late responses must be ignored (memory holds off the first restart
        // request so the stale word meets an idle fetch unit).
        reset_dut(3);
        repeat (7) cyc();
        samp();
        check("t6_pre_req_addr", imem_req_addr, 64'h100C);
        cyc();
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("t6_rst_req_valid", imem_req_valid, 1'b0);
        check("t6_rst_ready", IFID_ready, 1'b0);
        check("t6_rst_instr", IFID_instreg, 32'h0000_0013);
        check("t6_rst_npc", IFID_npc, 64'h0);
        cyc();
        reset = 1'b1;
        samp();
        check("t6_boot_req_valid", imem_req_valid, 1'b0);
        cyc();
        samp();
        check("t6_restart_addr", imem_req_addr, 64'h1000);
        cyc();
        mem_ready = 1'b1;
        samp();
        check("t6_restart_valid", imem_req_valid, 1'b1);
        check("t6_restart_addr2", imem_req_addr, 64'h1000);
        watch("t6", 64'h1000, 3, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the in-order RISC-V pipeline, and the producer side of the IF/ID interface that the decode stage consumes. Holds the PC and issues in-order 32-bit requests to instruction memory. Buffers returned instructions in a small FIFO and presents them to decode with ready/stall flow control. On an execute-stage branch redirect it flushes its buffer and discards stale in-flight responses.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, PC fetched first after reset
DEPTH, 2, instruction FIFO entries; also the cap on FIFO occupancy plus in-flight requests (power of 2, ≥2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  fetch address, bits[1:0] always 0
imem_resp_valid  in  1  in-order response valid (no backpressure)
imem_resp_data  in  32  instruction word
IFID_instreg  out  32  instruction at FIFO head
IFID_npc  out  64  PC of that instruction (its own address)
IFID_ready  out  1  head entry valid
IDIF_stall  in  1  decode cannot accept this cycle
EXIF_branch  in  1  redirect pulse from execute
EXIF_target  in  64  redirect PC
fetch_misaligned  out  1  sticky: a redirect target had bits[1:0]≠0

Behaviour:
- Reset (async assert, sync deassert):
  - pc=RESET_PC; FIFO empty; inflight=0; drop_cnt=0; state=BOOT.
  - Outputs: imem_req_valid=0, IFID_ready=0, IFID_instreg=32'h00000013, IFID_npc=0, fetch_misaligned=0.
  - A reset assertion mid-operation aborts everything. Responses arriving later are ignored while inflight=0.
- FSM:
  - BOOT: one cycle, no request issued. Moves to RUN.
  - RUN: normal operation. No other states; there is no halt.
- Request issue (RUN only):
  - imem_req_valid=1 iff count+inflight < DEPTH.
  - imem_req_addr=pc.
  - Accept (valid&&ready) increments inflight and sets pc+=4 (64-bit wrap).
- Response handling: each imem_resp_valid decrements inflight.
  - If drop_cnt>0: the word is discarded and drop_cnt decrements.
  - Otherwise it is pushed with its PC. The PC comes from a resp_pc register that tracks the PC of the oldest non-dropped outstanding request.
  - The credit rule guarantees the FIFO never overflows.
- Output side:
  - IFID_ready = count≠0; IFID_instreg and IFID_npc come from the head entry (registered storage).
  - Pop when IFID_ready && !IDIF_stall && !EXIF_branch.
  - While IDIF_stall=1 the head is held stable.
  - When empty, IFID_instreg=32'h00000013.
  - Push and pop in the same cycle leave count unchanged. A push into an empty FIFO is visible the next cycle (1-cycle latency from resp to IFID_ready).
- Redirect (EXIF_branch=1), has priority over all other events:
  - FIFO flushed (count=0 next cycle); no pop that cycle.
  - pc=resp_pc={EXIF_target[63:2],2'b00}.
  - If EXIF_target[1:0]≠0, fetch_misaligned is set (sticky until reset).
  - drop_cnt_next = inflight + (req accepted this cycle) − (resp this cycle). Every older request becomes stale, including one accepted in the same cycle; a same-cycle response is itself dropped.
  - New requests may issue the cycle after redirect, even while drop_cnt>0, subject to the credit rule (credits count inflight, which still includes requests pending drop).
  - Back-to-back redirects recompute drop_cnt with the same formula.
- Invariants, checked by assertions:
  - count+inflight ≤ DEPTH.
  - drop_cnt ≤ inflight.
  - imem_req_addr[1:0]==0.
  - imem_resp_valid never arrives with inflight=0 except after reset.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR=32'h00000013
  - XLEN=64
  - the fetch_state_e enum (BOOT, RUN)
  - an ifid_entry_t struct {instr[31:0], pc[63:0]}
- One sub-module, fetch_fifo: parameterised sync FIFO of ifid_entry_t with push/pop/flush and count, head read combinationally from registers.

Test Plan:
1. Reset, RESET_PC=64'h1000, zero-wait memory returning addr as data, IDIF_stall=0 -> requests 0x1000,0x1004,… one per cycle in steady state. IFID_npc sequence 0x1000,0x1004,… with matching IFID_instreg. First IFID_ready no later than cycle 3 after reset release.
2. Hold IDIF_stall=1 for 5 cycles with the FIFO filling -> IFID_instreg/IFID_npc constant. imem_req_valid drops once count+inflight=2. No entry lost or duplicated after the stall releases.
3. Memory latency 3 cycles, 2 requests in flight (0x1008,0x100C), EXIF_branch with EXIF_target=0x2000 -> IFID_ready=0 next cycle. Both old responses dropped. First delivered IFID_npc=0x2000.
4. EXIF_branch in the same cycle as a request accept and a response -> drop_cnt computed per formula. No instruction from the old path ever reaches IFID. Next fetch is 0x2000.
5. EXIF_target=0x3002 -> fetch_misaligned=1 and stays set. Fetch proceeds from 0x3000.
6. Assert reset for 1 cycle mid-stream with 2 requests in flight -> all outputs return to reset values immediately. Fetch restarts at RESET_PC with no stale delivery.
